// File: rtl/hwpe_tcdm_responder.sv
// rtl/hwpe_tcdm_responder.sv - multi-port word-interleaved TCDM responder with per-bank round-robin arbitration
// Optional grant stalling via LFSR when HWPE_TCDM_RESPONDER_STALL_EN is defined.
module hwpe_tcdm_responder #(
  parameter int MP         = 2,
  parameter int NB_BANKS   = 4,
  parameter int BANK_WORDS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o
);

  localparam int BANK_BITS = $clog2(NB_BANKS);
  localparam int ROW_BITS  = $clog2(BANK_WORDS);
  localparam int PTR_W     = (MP > 1) ? $clog2(MP) : 1;

  logic [BANK_BITS-1:0] port_bank [MP];
  logic [ROW_BITS-1:0]  port_row  [MP];
  logic [31:0]          mem       [NB_BANKS][BANK_WORDS];
  logic [PTR_W-1:0]     rr_ptr    [NB_BANKS];
  logic [PTR_W-1:0]     bank_win  [NB_BANKS];
  logic [NB_BANKS-1:0]  bank_act;
  logic [MP-1:0]        gnt;
  logic [MP-1:0]        r_valid_q;
  logic [MP-1:0][31:0]  r_data_q;
  logic                 stall;
  logic                 block;
  logic                 addr_unused;

  function automatic int rr_idx(input logic [PTR_W-1:0] base, input int k);
    return (int'(base) + k) % MP;
  endfunction

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] win);
    return PTR_W'((int'(win) + 1) % MP);
  endfunction

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign block = rst_i | stall;

  // Address bits above the row field wrap; the byte offset is irrelevant for word access.
  always_comb begin
    addr_unused = 1'b0;
    for (int p = 0; p < MP; p++) begin
      port_bank[p] = tcdm_add_i[p][BANK_BITS+1:2];
      port_row[p]  = tcdm_add_i[p][BANK_BITS+ROW_BITS+1:BANK_BITS+2];
      addr_unused  = addr_unused ^ (^tcdm_add_i[p][31:BANK_BITS+ROW_BITS+2]) ^ (^tcdm_add_i[p][1:0]);
    end
  end

  // Scan from farthest to nearest relative to the pointer so the nearest requester wins.
  always_comb begin
    bank_act = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      bank_win[b] = '0;
      for (int k = MP - 1; k >= 0; k--) begin
        if (tcdm_req_i[rr_idx(rr_ptr[b], k)] && (int'(port_bank[rr_idx(rr_ptr[b], k)]) == b)) begin
          bank_win[b] = PTR_W'(rr_idx(rr_ptr[b], k));
          bank_act[b] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int p = 0; p < MP; p++) begin
      gnt[p] = !block && bank_act[port_bank[p]] && (bank_win[port_bank[p]] == PTR_W'(p));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && !tcdm_wen_i[p]) begin
        for (int j = 0; j < 4; j++) begin
          if (tcdm_be_i[p][j]) begin
            mem[port_bank[p]][port_row[p]][8*j +: 8] <= tcdm_data_i[p][8*j +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      for (int b = 0; b < NB_BANKS; b++) begin
        rr_ptr[b] <= '0;
      end
    end else begin
      r_valid_q <= gnt;
      for (int p = 0; p < MP; p++) begin
        if (gnt[p] && tcdm_wen_i[p]) begin
          r_data_q[p] <= mem[port_bank[p]][port_row[p]];
        end
      end
      for (int b = 0; b < NB_BANKS; b++) begin
        if (bank_act[b] && !block) begin
          rr_ptr[b] <= rr_next(bank_win[b]);
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;

endmodule
